// File: rtl/score_bcd_tracker.sv
// Frame-driven packed-BCD score counter with optional high-score latch and glyph base addresses.
// Optional feature: define SCORE_HISCORE_EN to build the high-score register, compare and new_high pulse.
module score_bcd_tracker #(
  parameter int DIGITS     = 5,
  parameter int TICK_DIV   = 32,
  parameter int GLYPH_SIZE = 625,
  parameter int ADDR_W     = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_end,
  input  logic                     start,
  input  logic                     game_over,
  input  logic                     clear,
  output logic [4*DIGITS-1:0]      cur_bcd,
  output logic [4*DIGITS-1:0]      hi_bcd,
  output logic [ADDR_W*DIGITS-1:0] cur_base,
  output logic [ADDR_W*DIGITS-1:0] hi_base,
  output logic                     running,
  output logic                     saturated,
  output logic                     new_high,
  output logic [1:0]               state_o
);

  // Handshake: none; frame_end and clear are single-cycle strobes, start/game_over are levels.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [7:0]          DIV_LAST  = 8'(TICK_DIV - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t              state_q, state_d;
  logic [7:0]          div_q, div_d;
  logic [4*DIGITS-1:0] cur_q, cur_d, cur_inc;

  // Ripple-carry BCD increment: each digit wraps 9->0 while the carry keeps propagating.
  always_comb begin : bcd_inc
    logic carry;
    carry   = 1'b1;
    cur_inc = cur_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cur_q[4*i +: 4] == 4'd9) begin
          cur_inc[4*i +: 4] = 4'd0;
        end else begin
          cur_inc[4*i +: 4] = cur_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  assign saturated = (cur_q == ALL_NINES);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          cur_d = '0;
          div_d = '0;
        end
        if (start && !game_over) begin
          state_d = S_RUN;
          div_d   = '0;
        end
      end
      S_RUN: begin
        // A game_over on a tick cycle wins: the score freezes at its pre-tick value.
        if (game_over) begin
          state_d = S_OVER;
        end else if (frame_end) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!saturated) cur_d = cur_inc;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      S_OVER: begin
        if (clear) begin
          state_d = S_IDLE;
          cur_d   = '0;
          div_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cur_q   <= cur_d;
    end
  end

  assign cur_bcd = cur_q;
  assign running = (state_q == S_RUN);
  assign state_o = state_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cur_base
    assign cur_base[g*ADDR_W +: ADDR_W] = ADDR_W'(32'(cur_q[4*g +: 4]) * GLYPH_SIZE);
  end

`ifdef SCORE_HISCORE_EN
  logic                over_first_q, over_first_d;
  logic [4*DIGITS-1:0] hi_q, hi_d;
  logic                new_high_q, new_high_d;

  // Valid BCD digits order the same as the packed vector, so an unsigned compare is MSD-first.
  always_comb begin
    over_first_d = (state_q == S_RUN) && game_over;
    hi_d         = hi_q;
    new_high_d   = 1'b0;
    if (over_first_q && (cur_q > hi_q)) begin
      hi_d       = cur_q;
      new_high_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      over_first_q <= 1'b0;
      hi_q         <= '0;
      new_high_q   <= 1'b0;
    end else begin
      over_first_q <= over_first_d;
      hi_q         <= hi_d;
      new_high_q   <= new_high_d;
    end
  end

  assign hi_bcd   = hi_q;
  assign new_high = new_high_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_hi_base
    assign hi_base[g*ADDR_W +: ADDR_W] = ADDR_W'(32'(hi_q[4*g +: 4]) * GLYPH_SIZE);
  end
`else
  assign hi_bcd   = '0;
  assign hi_base  = '0;
  assign new_high = 1'b0;
`endif

endmodule

// File: doc/score_bcd_tracker.md
# score_bcd_tracker

Parametrised game-score engine for the dino VGA pipeline. It counts frames while the game runs and keeps an N-digit packed-BCD current score with ripple carry, so no divide or modulo hardware is needed. On game over it latches a high score and reports per-digit glyph base addresses for the digit-sprite RAMs. It sits between the frame timing generator (`frame_end`) and the VGA compositor.

## Interface
Parameters:
- `DIGITS`, 5, number of BCD digits; legal range 1–8.
- `TICK_DIV`, 32, `frame_end` pulses per score point; legal range 1–256.
- `GLYPH_SIZE`, 625, words per digit glyph in the digit RAM (25×25).
- `ADDR_W`, 14, width of each glyph base address.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clock is `clk`.
- `frame_end`  in  1  one-cycle pulse per frame, synchronous to `clk`.
- `start`  in  1  level; starts a run from IDLE.
- `game_over`  in  1  level; collision flag.
- `clear`  in  1  one-cycle pulse; returns from OVER to IDLE and zeroes the current score.
- `cur_bcd`  out  4*DIGITS  current score; digit 0 is in bits [3:0] and is least significant.
- `hi_bcd`  out  4*DIGITS  high score, same packing as `cur_bcd`.
- `cur_base`  out  ADDR_W*DIGITS  per-digit value × GLYPH_SIZE, for the current score.
- `hi_base`  out  ADDR_W*DIGITS  per-digit value × GLYPH_SIZE, for the high score.
- `running`  out  1  high when the state is RUN.
- `saturated`  out  1  current score is all 9s.
- `new_high`  out  1  one-cycle pulse when the high score is replaced.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - OVER: frozen.
- IDLE→RUN when `start`=1 and `game_over`=0.
- RUN→OVER when `game_over`=1.
- OVER→IDLE on `clear`.
- `clear` in IDLE zeroes the score and the divider. `clear` in RUN is ignored.
- Divider: 8-bit counter, advances only on `frame_end` while in RUN.
  - When it equals TICK_DIV-1 it wraps to 0 and issues an internal tick.
  - Divider resets to 0 on entry to RUN.
- Tick increments the current score in BCD:
  - A digit at 9 becomes 0 and carries into the next digit.
  - Each digit stays within 0–9 at all times.
- Saturation: when all digits are 9, ticks are dropped, `saturated`=1 and the score holds. No wrap to 0.
- Simultaneous `game_over` and tick in RUN: the transition wins and no increment occurs.
- High-score compare runs on the first cycle in OVER:
  - Digits are compared most significant first; the comparison is strictly greater-than.
  - If greater, `hi_bcd` takes `cur_bcd` and `new_high` pulses.
  - A tie does not pulse `new_high`.
  - Compare happens exactly once per OVER entry.
- `cur_base` and `hi_base` are combinational from the registered digits: slice i = digit_i × GLYPH_SIZE, truncated to ADDR_W.
- Reset mid-operation: state returns to IDLE. The current score, high score, divider, `saturated` and `new_high` all go to 0.

## Timing
- Reset values:
  - State IDLE; `cur_bcd`, `hi_bcd`, `cur_base` and `hi_base` all 0.
  - `running`, `saturated` and `new_high` are 0.
- All state and BCD registers update on `posedge clk`.
- Tick latency: the score changes on the edge that samples the qualifying `frame_end`, so it is visible one cycle after the pulse.
- `running` rises one cycle after `start` is sampled.
- Game-over edge E moves the state to OVER. On edge E+1 `hi_bcd` updates and `new_high` is 1 for one cycle.
- `clear` sampled in OVER: IDLE on the next edge, with `cur_bcd`=0 on that same edge.
- The `*_base` outputs follow their digits with zero added latency.

## Configuration
- `SCORE_HISCORE_EN` defined: high-score register, compare logic, `hi_bcd`, `hi_base` and `new_high` operate as described above.
- Not defined: none of that logic is built. `hi_bcd`, `hi_base` and `new_high` are tied to 0, and OVER entry performs no compare. All other behaviour is unchanged.

## Test plan
Unless noted, DIGITS=5, TICK_DIV=2, macro defined.
- Reset, then `start`=1, then 7 `frame_end` pulses → `cur_bcd`=0x00003; `running`=1.
- Preload the score to 0x00099, then one tick → 0x00100 (two carries in one cycle).
- Preload the score to 0x99999, then 4 ticks → stays at 0x99999 with `saturated`=1.
- Score 0x00042 with `game_over`=1 on a tick cycle → score stays 0x00042, state OVER. One cycle later `hi_bcd`=0x00042, `new_high`=1 for exactly 1 cycle, and `hi_base` digit1 = 4×625 = 2500.
- Second game ending at score 0x00042 (a tie), then `clear` → no `new_high` pulse; `hi_bcd` stays 0x00042; IDLE with `cur_bcd`=0.
- Assert `reset` mid-RUN at score 0x00017 → all outputs are 0 immediately and the state is IDLE.
